// File: rtl/i2c_pkg.sv
// ============================================================================
// Module : i2c_pkg
// Brief  : Shared types and defaults for the write-only I2C master.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4
  } state_e;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;
  localparam int         QUARTER_DEFAULT  = 39;
  localparam int         NUM_BYTES        = 3;

endpackage

`default_nettype wire

// File: rtl/i2c_qtick.sv
// ============================================================================
// Module : i2c_qtick
// Brief  : Quarter-bit divider; tick every QUARTER clocks plus 2-bit index.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_qtick #(
  parameter int QUARTER = 39
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart_i,
  output logic       tick_o,
  output logic [1:0] qidx_o
);

  localparam int CW = $clog2(QUARTER + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qidx_q, qidx_d;

  assign tick_o = (cnt_q == CW'(QUARTER - 1));
  assign qidx_o = qidx_q;

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    qidx_d = qidx_q;
    if (restart_i) begin
      cnt_d  = '0;
      qidx_d = '0;
    end else if (tick_o) begin
      cnt_d  = '0;
      qidx_d = qidx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      qidx_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      qidx_q <= qidx_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2c_master_tx.sv
// ============================================================================
// Module : i2c_master_tx
// Brief  : Write-only I2C master: START, addr(W), 2 data bytes, STOP w/ ACK check.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_master_tx
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int         QUARTER  = QUARTER_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic        start,
  output logic        done,
  output logic        error,
  inout  wire         i2c_scl,
  inout  wire         i2c_sda
);

  state_e      state_q, state_d;
  logic [23:0] shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic        error_q, error_d;
  logic        done_q, done_d;
  logic        scl_low_q, scl_low_d;
  logic        sda_low_q, sda_low_d;

  logic        restart;
  logic        tick;
  logic [1:0]  qidx;
  logic        bit_end;

  i2c_qtick #(.QUARTER(QUARTER)) u_qtick (
    .clk       (clk),
    .rst       (rst),
    .restart_i (restart),
    .tick_o    (tick),
    .qidx_o    (qidx)
  );

  assign bit_end = tick && (qidx == 2'd3);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    error_d    = error_q;
    done_d     = 1'b0;
    scl_low_d  = 1'b0;
    sda_low_d  = 1'b0;
    restart    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          restart    = 1'b1;
          shift_d    = {DEV_ADDR, 1'b0, data};
          error_d    = 1'b0;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        sda_low_d = (qidx != 2'd0);
        scl_low_d = (qidx == 2'd3);
        if (bit_end) state_d = ST_BIT;
      end
      ST_BIT: begin
        scl_low_d = !qidx[1];
        sda_low_d = !shift_q[23];
        if (bit_end) begin
          shift_d   = {shift_q[22:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        scl_low_d = !qidx[1];
        // Sample mid SCL-high; error_q doubles as the NACK flag for this byte.
        if (tick && (qidx == 2'd2)) error_d = i2c_sda;
        if (bit_end) begin
          if (error_q || (byte_cnt_q == 2'(NUM_BYTES - 1))) begin
            state_d = ST_STOP;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            state_d    = ST_BIT;
          end
        end
      end
      ST_STOP: begin
        scl_low_d = (qidx == 2'd0);
        sda_low_d = !qidx[1];
        if (bit_end) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
      scl_low_q  <= 1'b0;
      sda_low_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      error_q    <= error_d;
      done_q     <= done_d;
      scl_low_q  <= scl_low_d;
      sda_low_q  <= sda_low_d;
    end
  end

  assign done    = done_q;
  assign error   = error_q;
  assign i2c_scl = scl_low_q ? 1'b0 : 1'bz;
  assign i2c_sda = sda_low_q ? 1'b0 : 1'bz;

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_tx.sv
// ============================================================================
// Module : tb_i2c_master_tx
// Brief  : Directed bench with bus monitor and ACK/NACK slave for i2c_master_tx.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_master_tx;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [15:0] data  = 16'h0000;
  logic        done;
  logic        error;
  wire         scl;
  wire         sda;
  logic        slv_low = 1'b0;

  assign sda = slv_low ? 1'b0 : 1'bz;
  pullup (scl);
  pullup (sda);

  always #10 clk = ~clk;

  i2c_master_tx dut (
    .clk     (clk),
    .rst     (rst),
    .data    (data),
    .start   (start),
    .done    (done),
    .error   (error),
    .i2c_scl (scl),
    .i2c_sda (sda)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   n_start, n_stop, n_done, n_edge;
  int   slv_bits, slv_byte;
  logic [2:0] nack_mask = 3'b000;
  logic bits_q[$];
  logic p_scl = 1'b1;
  logic p_sda = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor plus a slave that ACKs unless its nack_mask bit is set.
  always @(negedge clk) begin
    logic c_scl, c_sda;
    c_scl = scl;
    c_sda = sda;
    if (c_scl !== p_scl || c_sda !== p_sda) n_edge++;
    if (done) n_done++;
    if (p_scl && c_scl && p_sda && !c_sda) begin
      n_start++;
      bits_q.delete();
      slv_bits = -1;
      slv_byte = 0;
      slv_low  = 1'b0;
    end
    if (p_scl && c_scl && !p_sda && c_sda) n_stop++;
    if (!p_scl && c_scl) bits_q.push_back(c_sda);
    if (p_scl && !c_scl) begin
      slv_bits++;
      if (slv_bits == 8) begin
        slv_low = (slv_byte < 3) ? !nack_mask[slv_byte] : 1'b0;
      end else if (slv_bits == 9) begin
        slv_low  = 1'b0;
        slv_bits = 0;
        slv_byte++;
      end
    end
    p_scl = c_scl;
    p_sda = c_sda;
  end

  task automatic xfer(input logic [15:0] d, input logic [2:0] nm, input int repulse_at);
    int         lat, nb, ng, qtr;
    logic [7:0] exp_b [3];
    logic [7:0] b;
    nb = nm[0] ? 1 : (nm[1] ? 2 : 3);
    qtr = 4 + nb * 36 + 4;
    exp_b[0] = 8'h34;
    exp_b[1] = d[15:8];
    exp_b[2] = d[7:0];
    nack_mask = nm;
    @(negedge clk);
    n_done  = 0;
    n_start = 0;
    n_stop  = 0;
    data    = d;
    start   = 1'b1;
    lat     = 0;
    while (lat < 6000 && !done) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        data  = 16'hFFFF;
        check("err_clear_on_accept", {31'd0, error}, 32'd0);
      end
      if (repulse_at != 0 && lat == repulse_at) begin
        start = 1'b1;
        data  = 16'h5555;
      end
      if (repulse_at != 0 && lat == repulse_at + 1) start = 1'b0;
    end
    check("latency", lat - 1, qtr * 39);
    repeat (200) @(negedge clk);
    check("done_count", n_done, 1);
    check("error", {31'd0, error}, {31'd0, (nm != 3'b000)});
    check("start_cond", n_start, 1);
    check("stop_cond", n_stop, 1);
    check("idle_scl", {31'd0, scl}, 32'd1);
    check("idle_sda", {31'd0, sda}, 32'd1);
    ng = bits_q.size() / 9;
    check("byte_count", ng, nb);
    for (int i = 0; i < ng && i < 3; i++) begin
      b = 8'h00;
      for (int j = 0; j < 8; j++) b = {b[6:0], bits_q[9 * i + j]};
      check($sformatf("byte%0d", i), {24'd0, b}, {24'd0, exp_b[i]});
      check($sformatf("ack%0d", i), {31'd0, bits_q[9 * i + 8]}, {31'd0, nm[i]});
    end
  endtask

  initial begin
    // Reset held: outputs quiet, bus released, no activity for 10 us.
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    n_edge = 0;
    repeat (500) @(negedge clk);
    check("rst_edges", n_edge, 0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_scl", {31'd0, scl}, 32'd1);
    check("rst_sda", {31'd0, sda}, 32'd1);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    xfer(16'hDEAD, 3'b000, 0);   // all ACK
    xfer(16'hDEAD, 3'b001, 0);   // NACK on address
    xfer(16'hDEAD, 3'b100, 0);   // NACK on last byte
    xfer(16'hBEEF, 3'b010, 1000); // re-pulse ignored, NACK on 2nd byte
    xfer(16'h0123, 3'b000, 0);   // error cleared

    // Reset mid-byte while master is driving SDA low.
    nack_mask = 3'b000;
    @(negedge clk);
    data  = 16'hDEAD;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (1999) @(negedge clk);
    check("pre_rst_sda", {31'd0, sda}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("midrst_scl", {31'd0, scl}, 32'd1);
    check("midrst_sda", {31'd0, sda}, 32'd1);
    n_done = 0;
    repeat (5) @(negedge clk);
    check("midrst_done", n_done, 0);
    check("midrst_error", {31'd0, error}, 32'd0);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    check("midrst_no_stop_gen", {31'd0, scl & sda}, 32'd1);
    xfer(16'hC3A5, 3'b000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
